// File: rtl/instr_loader_pkg.sv
// Shared types and constants for the instruction loader.
// Provides the FSM state enum, byte/word geometry and the default buffer depth.
package instr_loader_pkg;

  localparam int unsigned DEPTH_DEFAULT  = 32;
  localparam int unsigned BYTES_PER_WORD = 4;
  localparam int unsigned BYTE_W         = 8;
  localparam int unsigned WORD_W         = BYTE_W * BYTES_PER_WORD;
  localparam int unsigned TOTAL_W        = 7;
  localparam int unsigned BCNT_W         = $clog2(BYTES_PER_WORD);

  typedef enum logic [2:0] {
    ST_IDLE    = 3'd0,
    ST_COLLECT = 3'd1,
    ST_BURST   = 3'd2,
    ST_FLUSH   = 3'd3,
    ST_RUN     = 3'd4
  } state_e;

endpackage

// File: rtl/instr_loader_if.sv
// Host-side bus of the instruction loader.
// master: program source / controller (drives start, word_total, byte stream).
// slave : the loader (drives byte_ready, CPU load port, status flags).
interface instr_loader_if import instr_loader_pkg::*; ();

  logic                 start;
  logic [TOTAL_W-1:0]   word_total;
  logic                 byte_valid;
  logic [BYTE_W-1:0]    byte_data;
  logic                 byte_ready;
  logic [WORD_W-1:0]    Instruction;
  logic                 LoadInstructions;
  logic                 cpu_reset;
  logic                 busy;
  logic                 done;
  logic                 err;

  modport master (
    output start, word_total, byte_valid, byte_data,
    input  byte_ready, Instruction, LoadInstructions, cpu_reset, busy, done, err
  );

  modport slave (
    input  start, word_total, byte_valid, byte_data,
    output byte_ready, Instruction, LoadInstructions, cpu_reset, busy, done, err
  );

endinterface

// File: rtl/instr_loader_buf.sv
// Program word buffer: DEPTH x 32, one synchronous write port and a read port
// with one-cycle latency.
// Ports: clk, rst_n (async, resets only the read register), we/wr_addr/wr_data,
//        rd_en/rd_addr, rd_data (registered; zero when rd_en was low).
module instr_loader_buf import instr_loader_pkg::*; #(
  parameter  int unsigned DEPTH = DEPTH_DEFAULT,
  localparam int unsigned AW    = $clog2(DEPTH)
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic              we,
  input  logic [AW-1:0]     wr_addr,
  input  logic [WORD_W-1:0] wr_data,
  input  logic              rd_en,
  input  logic [AW-1:0]     rd_addr,
  output logic [WORD_W-1:0] rd_data
);

  logic [WORD_W-1:0] mem [DEPTH];

  // Storage, no reset needed.
  always_ff @(posedge clk) begin
    if (we) begin
      mem[wr_addr] <= wr_data;
    end
  end

  // Read register; a same-cycle write to the read address is forwarded so a
  // word completed on the final byte can be presented on the very next cycle.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      rd_data <= '0;
    end else if (rd_en) begin
      rd_data <= (we && (wr_addr == rd_addr)) ? wr_data : mem[rd_addr];
    end else begin
      rd_data <= '0;
    end
  end

endmodule

// File: rtl/instr_loader.sv
// Instruction loader: collects a byte stream (MSB first) into 32-bit words,
// buffers a program of word_total words, then bursts it into the CPU
// instruction memory while holding the CPU in reset, and finally releases it.
// Ports: clk, Reset (async active-low), bus (instr_loader_if.slave).
module instr_loader import instr_loader_pkg::*; #(
  parameter int unsigned DEPTH = DEPTH_DEFAULT
) (
  input  logic          clk,
  input  logic          Reset,
  instr_loader_if.slave bus
);

  localparam int unsigned AW    = $clog2(DEPTH);
  localparam int unsigned PTR_W = AW + 1;

  state_e                   state_q, state_d;
  logic [PTR_W-1:0]         wr_ptr_q, rd_ptr_q, total_q;
  logic [BCNT_W-1:0]        bcnt_q;
  logic [WORD_W-BYTE_W-1:0] asm_q;
  logic                     flush_q;

  logic start_seen, start_bad, start_ok;
  logic accept, word_done, last_word;
  logic byte_ready_d, load_d, cpu_reset_d, busy_d, done_d, err_d, rd_en;
  logic [WORD_W-1:0] rd_data;

  // Start decode: only honoured from IDLE or RUN.
  assign start_seen = bus.start && ((state_q == ST_IDLE) || (state_q == ST_RUN));
  assign start_bad  = start_seen &&
                      ((bus.word_total == '0) || (bus.word_total > TOTAL_W'(DEPTH)));
  assign start_ok   = start_seen && !start_bad;

  // Byte handshake and word completion.
  assign accept    = bus.byte_valid && bus.byte_ready;
  assign word_done = accept && (bcnt_q == BCNT_W'(BYTES_PER_WORD - 1));
  assign last_word = word_done && ((wr_ptr_q + PTR_W'(1)) == total_q);

  // State register.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      state_q <= ST_IDLE;
    end else begin
      state_q <= state_d;
    end
  end

  // Next-state logic.
  always_comb begin
    state_d = state_q;
    case (state_q)
      ST_IDLE, ST_RUN: if (start_ok)               state_d = ST_COLLECT;
      ST_COLLECT:      if (last_word)              state_d = ST_BURST;
      ST_BURST:        if (rd_ptr_q == total_q)    state_d = ST_FLUSH;
      ST_FLUSH:        if (flush_q)                state_d = ST_RUN;
      default:                                     state_d = ST_IDLE;
    endcase
  end

  // Output decode from the next state, so every flag is registered in step
  // with the state. Buffer read is issued one cycle ahead of each BURST cycle.
  always_comb begin
    byte_ready_d = 1'b0;
    load_d       = 1'b0;
    cpu_reset_d  = 1'b1;
    busy_d       = 1'b0;
    done_d       = 1'b0;
    err_d        = start_bad;
    rd_en        = 1'b0;
    case (state_d)
      ST_COLLECT: begin
        byte_ready_d = 1'b1;
        busy_d       = 1'b1;
      end
      ST_BURST: begin
        load_d = 1'b1;
        busy_d = 1'b1;
        rd_en  = 1'b1;
      end
      ST_FLUSH: busy_d = 1'b1;
      ST_RUN: begin
        cpu_reset_d = 1'b0;
        done_d      = 1'b1;
      end
      default: ;
    endcase
  end

  // Registered outputs.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      bus.byte_ready       <= 1'b0;
      bus.LoadInstructions <= 1'b0;
      bus.cpu_reset        <= 1'b1;
      bus.busy             <= 1'b0;
      bus.done             <= 1'b0;
      bus.err              <= 1'b0;
    end else begin
      bus.byte_ready       <= byte_ready_d;
      bus.LoadInstructions <= load_d;
      bus.cpu_reset        <= cpu_reset_d;
      bus.busy             <= busy_d;
      bus.done             <= done_d;
      bus.err              <= err_d;
    end
  end

  // Pointers, byte assembly and flush timer. Pointers carry one extra bit so
  // a full DEPTH-word program is distinguishable from an empty one.
  always_ff @(posedge clk or negedge Reset) begin
    if (!Reset) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      total_q  <= '0;
      bcnt_q   <= '0;
      asm_q    <= '0;
      flush_q  <= 1'b0;
    end else begin
      flush_q <= (state_q == ST_FLUSH);
      if (start_ok) begin
        wr_ptr_q <= '0;
        rd_ptr_q <= '0;
        bcnt_q   <= '0;
        total_q  <= PTR_W'(bus.word_total);
      end else begin
        if (accept) begin
          bcnt_q <= bcnt_q + BCNT_W'(1);
          asm_q  <= {asm_q[WORD_W-2*BYTE_W-1:0], bus.byte_data};
          if (word_done) begin
            wr_ptr_q <= wr_ptr_q + PTR_W'(1);
          end
        end
        if (rd_en) begin
          rd_ptr_q <= rd_ptr_q + PTR_W'(1);
        end
      end
    end
  end

  instr_loader_buf #(.DEPTH(DEPTH)) u_buf (
    .clk     (clk),
    .rst_n   (Reset),
    .we      (word_done),
    .wr_addr (wr_ptr_q[AW-1:0]),
    .wr_data ({asm_q, bus.byte_data}),
    .rd_en   (rd_en),
    .rd_addr (rd_ptr_q[AW-1:0]),
    .rd_data (rd_data)
  );

  assign bus.Instruction = rd_data;

endmodule

// File: tb/tb_instr_loader.sv
// Self-checking bench for instr_loader: a table of start requests (rejected
// and accepted), fixed programs, randomized programs with byte gaps, start
// pokes mid-load and a mid-load reset. Expected words come from a queue of
// program words; expected timing from the load protocol itself.
module tb_instr_loader;
  import instr_loader_pkg::*;

  localparam int unsigned DEPTH = 32;

  typedef struct {
    logic [6:0] word_total;
    int         gap_pct;
    bit         exp_err;
  } vec_t;

  logic clk;
  logic Reset;
  int   errors;
  int   checks;
  bit   in_run;
  logic [31:0] exp_words[$];
  vec_t vecs[7];

  initial clk = 1'b0;
  always #5 clk = ~clk;

  instr_loader_if bus();

  instr_loader #(.DEPTH(DEPTH)) dut (
    .clk   (clk),
    .Reset (Reset),
    .bus   (bus)
  );

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      errors++;
      $display("FAIL %s: got %h expected %h (t=%0t)", name, act, exp, $time);
    end
  endtask

  task automatic tick;
    @(posedge clk);
    #1;
  endtask

  task automatic fill_random(input int n);
    exp_words.delete();
    for (int i = 0; i < n; i++) exp_words.push_back($urandom);
  endtask

  // Full load of exp_words: start, byte stream, burst, flush, run.
  task automatic run_load(input int n, input int gap_pct, input bit poke_collect,
                          input bit poke_burst);
    bus.start      = 1'b1;
    bus.word_total = 7'(n);
    tick;
    bus.start = 1'b0;
    // {byte_ready, busy, cpu_reset, done, err, LoadInstructions}
    chk("start_accept", 32'({bus.byte_ready, bus.busy, bus.cpu_reset, bus.done,
                             bus.err, bus.LoadInstructions}), 32'('b111000));
    for (int w = 0; w < n; w++) begin
      for (int b = 0; b < 4; b++) begin
        for (int g = 0; g < 3 && int'($urandom_range(99)) < gap_pct; g++) begin
          bus.byte_valid = 1'b0;
          tick;
        end
        chk("collect_hs", 32'({bus.byte_ready, bus.LoadInstructions}), 32'('b10));
        bus.byte_valid = 1'b1;
        bus.byte_data  = 8'(exp_words[w] >> (8 * (3 - b)));
        if (poke_collect && w == 0 && b == 1) begin
          bus.start      = 1'b1;
          bus.word_total = 7'd1;
        end
        tick;
        bus.start = 1'b0;
      end
    end
    bus.byte_valid = 1'b0;
    for (int k = 0; k < n; k++) begin
      // {LoadInstructions, byte_ready, busy, err}
      chk("burst_flags", 32'({bus.LoadInstructions, bus.byte_ready, bus.busy, bus.err}),
          32'('b1010));
      chk("burst_word", bus.Instruction, exp_words[k]);
      if (poke_burst && k == 0) begin
        bus.start      = 1'b1;
        bus.word_total = 7'd1;
      end
      tick;
      bus.start = 1'b0;
    end
    for (int f = 0; f < 2; f++) begin
      // {LoadInstructions, cpu_reset, busy, done}
      chk("flush_flags", 32'({bus.LoadInstructions, bus.cpu_reset, bus.busy, bus.done}),
          32'('b0110));
      chk("flush_instr", bus.Instruction, 32'h0);
      tick;
    end
    // {LoadInstructions, cpu_reset, busy, done, byte_ready, err}
    chk("run_flags", 32'({bus.LoadInstructions, bus.cpu_reset, bus.busy, bus.done,
                          bus.byte_ready, bus.err}), 32'('b000100));
    in_run = 1'b1;
  endtask

  // Rejected start: err for one cycle, state untouched.
  task automatic bad_start(input logic [6:0] wt);
    logic [3:0] sig;
    sig = {1'b0, 1'b0, in_run, ~in_run};  // {busy, byte_ready, done, cpu_reset}
    bus.start      = 1'b1;
    bus.word_total = wt;
    tick;
    bus.start = 1'b0;
    chk("err_pulse", 32'(bus.err), 32'h1);
    chk("err_state", 32'({bus.busy, bus.byte_ready, bus.done, bus.cpu_reset}), 32'(sig));
    tick;
    chk("err_clear", 32'(bus.err), 32'h0);
    chk("err_state2", 32'({bus.busy, bus.byte_ready, bus.done, bus.cpu_reset}), 32'(sig));
  endtask

  initial begin
    int n;
    errors         = 0;
    checks         = 0;
    in_run         = 1'b0;
    Reset          = 1'b0;
    bus.start      = 1'b0;
    bus.word_total = '0;
    bus.byte_valid = 1'b0;
    bus.byte_data  = '0;

    vecs[0] = '{7'd0,           0,  1'b1};
    vecs[1] = '{7'(DEPTH + 1),  0,  1'b1};
    vecs[2] = '{7'd1,           50, 1'b0};
    vecs[3] = '{7'd127,         0,  1'b1};
    vecs[4] = '{7'd0,           0,  1'b1};
    vecs[5] = '{7'(DEPTH),      40, 1'b0};
    vecs[6] = '{7'd5,           20, 1'b0};

    // Reset values while Reset is low.
    #12;
    // {byte_ready, LoadInstructions, cpu_reset, busy, done, err}
    chk("reset_flags", 32'({bus.byte_ready, bus.LoadInstructions, bus.cpu_reset, bus.busy,
                            bus.done, bus.err}), 32'('b001000));
    chk("reset_instr", bus.Instruction, 32'h0);
    Reset = 1'b1;
    tick;
    chk("idle_flags", 32'({bus.byte_ready, bus.busy, bus.done, bus.cpu_reset}), 32'('b0001));

    // Start-request table.
    for (int i = 0; i < 7; i++) begin
      if (vecs[i].exp_err) begin
        bad_start(vecs[i].word_total);
      end else begin
        fill_random(int'(vecs[i].word_total));
        run_load(int'(vecs[i].word_total), vecs[i].gap_pct, 1'b0, 1'b0);
      end
    end

    // Two-word program, back-to-back bytes.
    exp_words.delete();
    exp_words.push_back(32'h8C010004);
    exp_words.push_back(32'h00221820);
    run_load(2, 0, 1'b0, 1'b0);

    // Starts during COLLECT and BURST are ignored; start from RUN reloads.
    fill_random(4);
    run_load(4, 25, 1'b1, 1'b1);

    // Randomized programs.
    for (int r = 0; r < 3; r++) begin
      n = int'($urandom_range(DEPTH, 1));
      fill_random(n);
      run_load(n, int'($urandom_range(50)), 1'($urandom), 1'($urandom));
    end

    // Reset after 5 bytes of a 3-word load, then a fresh 1-word load.
    fill_random(3);
    bus.start      = 1'b1;
    bus.word_total = 7'd3;
    tick;
    bus.start = 1'b0;
    for (int i = 0; i < 5; i++) begin
      bus.byte_valid = 1'b1;
      bus.byte_data  = 8'(exp_words[i / 4] >> (8 * (3 - (i % 4))));
      tick;
    end
    bus.byte_valid = 1'b0;
    Reset = 1'b0;
    #1;
    chk("midload_reset_flags", 32'({bus.byte_ready, bus.LoadInstructions, bus.cpu_reset,
                                    bus.busy, bus.done, bus.err}), 32'('b001000));
    chk("midload_reset_instr", bus.Instruction, 32'h0);
    #2;
    Reset = 1'b1;
    tick;
    chk("post_reset_idle", 32'({bus.byte_ready, bus.busy, bus.done, bus.cpu_reset,
                                bus.LoadInstructions}), 32'('b00010));
    in_run = 1'b0;
    exp_words.delete();
    exp_words.push_back(32'hDEADBEEF);
    run_load(1, 0, 1'b0, 1'b0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
